// File: rtl/rom_arbiter_pkg.sv
// Shared helpers for the boot-ROM arbiter.
package rom_arbiter_pkg;

  // Round-robin pick between the two ports: on a tie the port that was not
  // granted last wins, otherwise the single requester wins.
  function automatic logic rr_pick(input logic req0, input logic req1,
                                   input logic last_grant);
    logic pick;
    if (req0 && req1) begin
      pick = ~last_grant;
    end else if (req1) begin
      pick = 1'b1;
    end else begin
      pick = 1'b0;
    end
    return pick;
  endfunction

endpackage

// File: rtl/rom_arbiter.sv
// Boot-ROM arbiter: shares a byte-wide synchronous-read ROM between the
// fetch port (0) and the load port (1), reads WORD_BYTES consecutive bytes
// and returns them as a little-endian word with a one-cycle acknowledge.
module rom_arbiter
  import rom_arbiter_pkg::*;
#(
  parameter int ADDR_W     = 7,
  parameter int WORD_BYTES = 2
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    req0,
  input  logic                    req1,
  input  logic [ADDR_W-1:0]       addr0,
  input  logic [ADDR_W-1:0]       addr1,
  output logic                    ack0,
  output logic                    ack1,
  output logic [8*WORD_BYTES-1:0] rdata,
  output logic                    busy,
  output logic                    rom_enable,
  output logic [ADDR_W-1:0]       rom_addr,
  input  logic [7:0]              rom_data
);

  localparam int CNT_W = $clog2(WORD_BYTES + 1);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_READ = 2'd1;
  localparam logic [1:0] ST_ACK  = 2'd2;

  // Last READ cycle (data for the final byte arrives) and last cycle that
  // still issues a new ROM address.
  localparam logic [CNT_W-1:0] CNT_LAST      = CNT_W'(WORD_BYTES);
  localparam logic [CNT_W-1:0] CNT_ADDR_LAST = CNT_W'(WORD_BYTES - 1);

  logic [1:0]              state_r;
  logic [CNT_W-1:0]        cnt_r;
  logic                    owner_r;
  logic                    last_grant_r;
  logic                    ack0_r;
  logic                    ack1_r;
  logic                    busy_r;
  logic                    rom_enable_r;
  logic [ADDR_W-1:0]       rom_addr_r;
  logic [8*WORD_BYTES-1:0] word_r;

  logic                    any_req_s;
  logic                    pick_s;
  logic [ADDR_W-1:0]       base_s;

  // Grant selection and the base address of the port that would be granted.
  always_comb begin
    any_req_s = req0 | req1;
    pick_s    = rr_pick(req0, req1, last_grant_r);
    if (pick_s) begin
      base_s = addr1;
    end else begin
      base_s = addr0;
    end
  end

  // Arbitration FSM; the ROM address register doubles as the latched base
  // and walks forward one byte per READ cycle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r      <= ST_IDLE;
      cnt_r        <= '0;
      owner_r      <= 1'b0;
      last_grant_r <= 1'b1;
      ack0_r       <= 1'b0;
      ack1_r       <= 1'b0;
      busy_r       <= 1'b0;
      rom_enable_r <= 1'b0;
      rom_addr_r   <= '0;
      word_r       <= '0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (any_req_s) begin
            state_r      <= ST_READ;
            owner_r      <= pick_s;
            cnt_r        <= '0;
            rom_enable_r <= 1'b1;
            rom_addr_r   <= base_s;
            busy_r       <= 1'b1;
          end
        end
        ST_READ: begin
          // ROM data lags the address by one cycle, so lane cnt-1 lands now.
          for (int i = 0; i < WORD_BYTES; i++) begin
            if (cnt_r == CNT_W'(i + 1)) begin
              word_r[8*i +: 8] <= rom_data;
            end
          end
          if (cnt_r < CNT_ADDR_LAST) begin
            rom_addr_r <= rom_addr_r + ADDR_W'(1);
          end
          if (cnt_r == CNT_LAST) begin
            state_r      <= ST_ACK;
            rom_enable_r <= 1'b0;
            ack0_r       <= ~owner_r;
            ack1_r       <= owner_r;
          end else begin
            cnt_r <= cnt_r + CNT_W'(1);
          end
        end
        ST_ACK: begin
          state_r      <= ST_IDLE;
          ack0_r       <= 1'b0;
          ack1_r       <= 1'b0;
          busy_r       <= 1'b0;
          cnt_r        <= '0;
          last_grant_r <= owner_r;
        end
        default: begin
          state_r      <= ST_IDLE;
          ack0_r       <= 1'b0;
          ack1_r       <= 1'b0;
          busy_r       <= 1'b0;
          rom_enable_r <= 1'b0;
          cnt_r        <= '0;
        end
      endcase
    end
  end

  assign ack0       = ack0_r;
  assign ack1       = ack1_r;
  assign busy       = busy_r;
  assign rom_enable = rom_enable_r;
  assign rom_addr   = rom_addr_r;
  assign rdata      = word_r;

endmodule
